// File: rtl/myproject_sdiv_24s_8ns_16_seq.sv
// Sequential signed-by-unsigned restoring divider with a saturated quotient.
// Produces one quotient bit per cycle and holds the result under a valid/ready handshake.
module myproject_sdiv_24s_8ns_16_seq #(
    parameter int unsigned din0_WIDTH = 24,
    parameter int unsigned din1_WIDTH = 8,
    parameter int unsigned dout_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] dout_rem,
    output logic                  ovf,
    output logic                  div_zero
);

    localparam int unsigned CW = $clog2(din0_WIDTH);
    localparam int unsigned RW = din1_WIDTH + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(din0_WIDTH - 1);
    localparam logic [din0_WIDTH-1:0] Q_POS_MAX = din0_WIDTH'((64'd1 << (dout_WIDTH - 1)) - 64'd1);
    localparam logic [din0_WIDTH-1:0] Q_NEG_MAG = din0_WIDTH'(64'd1 << (dout_WIDTH - 1));
    localparam logic [dout_WIDTH-1:0] SAT_POS = {1'b0, {(dout_WIDTH - 1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] SAT_NEG = {1'b1, {(dout_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [din0_WIDTH-1:0]   r_dvd;
    logic [din1_WIDTH-1:0]   r_dvs;
    logic [RW-1:0]           r_rem;
    logic [CW-1:0]           r_cnt;
    logic                    r_neg;
    logic                    r_dz;

    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [dout_WIDTH-1:0]   r_dout;
    logic [din1_WIDTH-1:0]   r_rem_out;
    logic                    r_ovf;
    logic                    r_div_zero;

    logic                    w_accept;
    logic [din0_WIDTH-1:0]   w_abs;
    logic [RW:0]             w_shift;
    logic                    w_ge;
    logic [RW-1:0]           w_rem_step;

    logic                    w_in_ready_nxt;
    logic                    w_out_valid_nxt;
    logic [dout_WIDTH-1:0]   w_dout_nxt;
    logic [din1_WIDTH-1:0]   w_rem_out_nxt;
    logic                    w_ovf_nxt;
    logic                    w_div_zero_nxt;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign dout_rem  = r_rem_out;
    assign ovf       = r_ovf;
    assign div_zero  = r_div_zero;

    assign w_accept = (r_state == S_IDLE) && r_in_ready && in_valid;
    // Magnitude of the dividend; the most negative value maps to 2^(W-1) unsigned.
    assign w_abs    = din0[din0_WIDTH-1] ? din0_WIDTH'(-din0) : din0;

    // One restoring step: shift in the next dividend bit and conditionally subtract.
    assign w_shift    = {r_rem, r_dvd[din0_WIDTH-1]};
    assign w_ge       = (w_shift >= (RW + 1)'(r_dvs));
    assign w_rem_step = w_ge ? RW'(w_shift - (RW + 1)'(r_dvs)) : RW'(w_shift);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (din1 == '0) ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == LAST_BIT) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Result registers only change on the FIX cycle; r_dvd holds the quotient magnitude there.
    always_comb begin
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
        w_dout_nxt      = r_dout;
        w_rem_out_nxt   = r_rem_out;
        w_ovf_nxt       = r_ovf;
        w_div_zero_nxt  = r_div_zero;
        if (r_state == S_FIX) begin
            if (r_dz) begin
                w_dout_nxt     = r_neg ? SAT_NEG : SAT_POS;
                w_rem_out_nxt  = '0;
                w_ovf_nxt      = 1'b1;
                w_div_zero_nxt = 1'b1;
            end else if (!r_neg) begin
                w_div_zero_nxt = 1'b0;
                w_rem_out_nxt  = din1_WIDTH'(r_rem);
                if (r_dvd > Q_POS_MAX) begin
                    w_dout_nxt = SAT_POS;
                    w_ovf_nxt  = 1'b1;
                end else begin
                    w_dout_nxt = dout_WIDTH'(r_dvd);
                    w_ovf_nxt  = 1'b0;
                end
            end else begin
                w_div_zero_nxt = 1'b0;
                w_rem_out_nxt  = din1_WIDTH'(-r_rem);
                if (r_dvd > Q_NEG_MAG) begin
                    w_dout_nxt = SAT_NEG;
                    w_ovf_nxt  = 1'b1;
                end else begin
                    w_dout_nxt = dout_WIDTH'(-r_dvd);
                    w_ovf_nxt  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_dz        <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_rem_out   <= '0;
            r_ovf       <= 1'b0;
            r_div_zero  <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_dout      <= w_dout_nxt;
            r_rem_out   <= w_rem_out_nxt;
            r_ovf       <= w_ovf_nxt;
            r_div_zero  <= w_div_zero_nxt;
            if (w_accept) begin
                r_dvd <= w_abs;
                r_dvs <= din1;
                r_neg <= din0[din0_WIDTH-1];
                r_dz  <= (din1 == '0);
                r_rem <= '0;
                r_cnt <= '0;
            end else if (r_state == S_CALC) begin
                r_dvd <= {r_dvd[din0_WIDTH-2:0], w_ge};
                r_rem <= w_rem_step;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule
